map_render_ctrl: RTL and testbench

Sequences the per-pixel map renderer for the VGA output path. Generates 640x480 VGA timing from a pixel-enable tick, places a MAP_WIDTH_X x MAP_WIDTH_Y map viewport on screen, and drives the renderer's `map_x`/`map_y`/`map_on` with camera-scroll offset and wrap-around. Accepts scroll updates through a valid/ready handshake and applies them only at frame boundaries. Merges map and sprite colours in a registered output stage with sync signals delay-matched.

---
 rtl/map_render_ctrl.sv | 115 +++++++++++
 tb/tb_map_render_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/map_render_ctrl.sv
// map_render_ctrl: VGA timing, scrolled map viewport addressing, frame-synced scroll and colour merge
module map_render_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int MAP_WIDTH_X = 100,
  parameter int MAP_WIDTH_Y = 100,
  parameter int VIEW_X0 = 270,
  parameter int VIEW_Y0 = 190,
  parameter logic [11:0] BG_COLOR = 12'h222
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  scroll_x,
  input  logic [9:0]  scroll_y,
  input  logic        scroll_valid,
  output logic        scroll_ready,
  output logic [9:0]  map_x,
  output logic [9:0]  map_y,
  output logic        map_on,
  input  logic [11:0] map_rgb,
  input  logic        sprite_on,
  input  logic [11:0] sprite_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);
  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] X0  = 10'(VIEW_X0);
  localparam logic [9:0] X1  = 10'(VIEW_X0 + MAP_WIDTH_X);
  localparam logic [9:0] XL  = 10'(VIEW_X0 + MAP_WIDTH_X - 1);
  localparam logic [9:0] Y0  = 10'(VIEW_Y0);
  localparam logic [9:0] Y1  = 10'(VIEW_Y0 + MAP_WIDTH_Y);
  localparam logic [9:0] MXL = 10'(MAP_WIDTH_X - 1);
  localparam logic [9:0] MYL = 10'(MAP_WIDTH_Y - 1);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t state;
  logic [9:0] h_cnt, v_cnt, cur_x, cur_y, sh_x, sh_y, y_row, y_now;
  logic h_end, wrap, active, in_view, active_d, hsync_d, vsync_d;
  assign h_end = h_cnt == HL;
  assign wrap = pix_en && h_end && v_cnt == VL;
  assign frame_start = wrap && !rst;
  assign active = h_cnt < HA && v_cnt < VA;
  assign in_view = active && h_cnt >= X0 && h_cnt < X1 && v_cnt >= Y0 && v_cnt < Y1;
  assign y_now = v_cnt == Y0 ? cur_y : y_row;
  always_ff @(posedge clk)
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_end ? '0 : h_cnt + 10'd1;
      if (h_end) v_cnt <= v_cnt == VL ? '0 : v_cnt + 10'd1;
    end
  always_ff @(posedge clk)
    if (rst) begin
      map_x <= '0;
      map_y <= '0;
      map_on <= 1'b0;
      y_row <= '0;
      active_d <= 1'b0;
      hsync_d <= 1'b1;
      vsync_d <= 1'b1;
      rgb <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      map_x <= !in_view ? '0 : h_cnt == X0 ? cur_x : map_x == MXL ? '0 : map_x + 10'd1;
      map_y <= in_view ? y_now : '0;
      if (in_view && h_cnt == XL) y_row <= y_now == MYL ? '0 : y_now + 10'd1;
      map_on <= in_view;
      active_d <= active;
      hsync_d <= !(h_cnt >= HS0 && h_cnt < HS1);
      vsync_d <= !(v_cnt >= VS0 && v_cnt < VS1);
      rgb <= !active_d ? '0 : sprite_on ? sprite_rgb : map_on ? map_rgb : BG_COLOR;
      hsync <= hsync_d;
      vsync <= vsync_d;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      scroll_ready <= 1'b0;
      cur_x <= '0;
      cur_y <= '0;
      sh_x <= '0;
      sh_y <= '0;
    end else if (state == IDLE) begin
      if (scroll_valid && scroll_ready) begin
        sh_x <= scroll_x > MXL ? MXL : scroll_x;
        sh_y <= scroll_y > MYL ? MYL : scroll_y;
        state <= PENDING;
        scroll_ready <= 1'b0;
      end else begin
        scroll_ready <= 1'b1;
      end
    end else if (wrap) begin
      cur_x <= sh_x;
      cur_y <= sh_y;
      state <= IDLE;
      scroll_ready <= 1'b1;
    end
endmodule

// File: tb/tb_map_render_ctrl.sv
// tb_map_render_ctrl: reduced-geometry frames checked every clk against a pixel-formula reference model
module tb_map_render_ctrl;
  localparam int HA = 40, HF = 4, HS = 6, HB = 5;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int MW = 10, MH = 8, X0 = 12, Y0 = 9;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FT = HT * VT;
  localparam logic [11:0] BG = 12'h222;
  logic clk = 0, rst = 1, pix_en = 0, scroll_valid = 0, sprite_on = 0;
  logic scroll_ready, map_on, hsync, vsync, frame_start;
  logic [9:0] scroll_x = 0, scroll_y = 0, map_x, map_y;
  logic [11:0] map_rgb = 0, sprite_rgb = 0, rgb;
  int total = 0, bad = 0, ncyc = 0, pe_mode = 0;
  int m_t, cur_x, cur_y, sh_x, sh_y, s_mx, s_my;
  logic pend, e_rdy, s_act, s_on, s_hs, s_vs, e_hs, e_vs, acc;
  logic [11:0] e_rgb;
  always #5 clk = ~clk;
  map_render_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .MAP_WIDTH_X(MW), .MAP_WIDTH_Y(MH), .VIEW_X0(X0), .VIEW_Y0(Y0), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .scroll_valid(scroll_valid), .scroll_ready(scroll_ready),
    .map_x(map_x), .map_y(map_y), .map_on(map_on), .map_rgb(map_rgb),
    .sprite_on(sprite_on), .sprite_rgb(sprite_rgb),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_start(frame_start)
  );
  task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h t=%0d", tag, o, e, m_t);
    end
  endtask
  task automatic mreset();
    m_t = 0; cur_x = 0; cur_y = 0; sh_x = 0; sh_y = 0; s_mx = 0; s_my = 0;
    pend = 0; e_rdy = 0; s_act = 0; s_on = 0; s_hs = 1; s_vs = 1; e_hs = 1; e_vs = 1; e_rgb = '0;
  endtask
  task automatic model();
    int h, v;
    logic wrap;
    wrap = pix_en && m_t == FT - 1;
    acc = 0;
    if (rst) mreset();
    else begin
      if (pix_en) begin
        e_rgb = !s_act ? 12'h000 : sprite_on ? sprite_rgb : s_on ? map_rgb : BG;
        e_hs = s_hs;
        e_vs = s_vs;
        h = m_t % HT;
        v = m_t / HT;
        s_act = h < HA && v < VA;
        s_on = s_act && h >= X0 && h < X0 + MW && v >= Y0 && v < Y0 + MH;
        s_mx = s_on ? (cur_x + h - X0) % MW : 0;
        s_my = s_on ? (cur_y + v - Y0) % MH : 0;
        s_hs = !(h >= HA + HF && h < HA + HF + HS);
        s_vs = !(v >= VA + VF && v < VA + VF + VS);
        m_t = (m_t + 1) % FT;
      end
      acc = scroll_valid && e_rdy;
      if (pend && wrap) begin
        cur_x = sh_x;
        cur_y = sh_y;
        pend = 0;
      end else if (acc) begin
        sh_x = scroll_x > MW - 1 ? MW - 1 : int'(scroll_x);
        sh_y = scroll_y > MH - 1 ? MH - 1 : int'(scroll_y);
        pend = 1;
      end
      e_rdy = !pend;
    end
  endtask
  task automatic cyc();
    pix_en = pe_mode == 0 ? (ncyc % 4 == 0) : pe_mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
    sprite_on = $urandom_range(0, 3) == 0;
    sprite_rgb = 12'($urandom);
    map_rgb = 12'($urandom);
    @(negedge clk);
    chk("frame_start", 12'(frame_start), 12'(!rst && pix_en && m_t == FT - 1));
    chk("scroll_ready", 12'(scroll_ready), 12'(e_rdy));
    chk("map_on", 12'(map_on), 12'(s_on));
    chk("map_x", 12'(map_x), 12'(s_mx));
    chk("map_y", 12'(map_y), 12'(s_my));
    chk("rgb", rgb, e_rgb);
    chk("hsync", 12'(hsync), 12'(e_hs));
    chk("vsync", 12'(vsync), 12'(e_vs));
    model();
    @(posedge clk);
    #1;
    ncyc++;
  endtask
  task automatic go_to(input int tt);
    int n = 0;
    while (m_t != tt && n < 20000) begin
      cyc();
      n++;
    end
    total++;
    assert (m_t == tt) else begin
      bad++;
      $error("FAIL go_to_timeout obs=%0d exp=%0d", m_t, tt);
    end
  endtask
  task automatic req(input int x, input int y);
    int n = 0;
    scroll_valid = 1;
    scroll_x = 10'(x);
    scroll_y = 10'(y);
    acc = 0;
    while (!acc && n < 20000) begin
      cyc();
      n++;
    end
    scroll_valid = 0;
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL req_timeout obs=%0d exp=1", acc);
    end
  endtask
  initial begin
    mreset();
    @(posedge clk);
    #1;
    repeat (3) cyc();
    rst = 0;
    go_to(FT / 2);
    req(7, 6);
    req(3, 2);
    pe_mode = 2;
    go_to(FT - 1);
    go_to(0);
    go_to(FT - 1);
    scroll_valid = 1;
    scroll_x = 10'd200;
    scroll_y = 10'd300;
    pe_mode = 1;
    cyc();
    scroll_valid = 0;
    pe_mode = 2;
    go_to(FT / 3);
    go_to(FT - 1);
    go_to(0);
    go_to(FT / 4);
    req(1, 1);
    go_to(20 * HT + 5);
    rst = 1;
    cyc();
    cyc();
    rst = 0;
    go_to(FT - 1);
    go_to(0);
    go_to(FT / 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
